// File: rtl/cmp_pkg.sv
// cmp_pkg -- shared definitions for the serial magnitude comparator.
//   cmpState_t      : comparator FSM states (IDLE, CMP, DONE)
//   RES_GT/EQ/LT    : bit positions of the greater/equal/less flags in the
//                     result vector (driven out as l0/l1/l2)
//   mismatchResult  : builds the result vector for the first differing bit
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } cmpState_t;

  localparam int RES_GT = 0;
  localparam int RES_EQ = 1;
  localparam int RES_LT = 2;
  localparam int RES_W  = 3;

  // At the first differing bit, whichever operand holds the 1 is larger.
  // For the sign bit of a two's-complement pair the 1 marks the negative
  // operand, so the sense flips.
  function automatic logic [RES_W-1:0] mismatchResult(input logic bitA,
                                                      input logic bitB,
                                                      input logic invert);
    logic [RES_W-1:0] res;
    res         = '0;
    res[RES_GT] = invert ? bitB : bitA;
    res[RES_LT] = invert ? bitA : bitB;
    return res;
  endfunction

endpackage

// File: rtl/pb_edge.sv
// pb_edge -- registers one push-button input and flags its rising edge.
//   clk     : system clock
//   rst     : asynchronous active-high reset, clears the button history
//   pb_i    : raw button level
//   press_o : one-cycle pulse for each press; a held button pulses once
module pb_edge (
  input  logic clk,
  input  logic rst,
  input  logic pb_i,
  output logic press_o
);

  logic pbSync_q;
  logic pbPrev_q;

  // Two-stage history: the registered level and its previous value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pbSync_q <= 1'b0;
      pbPrev_q <= 1'b0;
    end else begin
      pbSync_q <= pb_i;
      pbPrev_q <= pbSync_q;
    end
  end

  assign press_o = pbSync_q & ~pbPrev_q;

endmodule

// File: rtl/nbit_serial_comp.sv
// nbit_serial_comp -- button-driven serial magnitude comparator.
// Operands A and B are entered CHUNK bits at a time; a compare walks the
// bits MSB first and stops at the first difference.
//   clk, rst      : clock and asynchronous active-high reset
//   y             : chunk shifted into A (pb1) and/or B (pb2)
//   pb1, pb2      : load-A / load-B buttons
//   pb3           : start compare
//   pb4           : toggle signed (two's-complement) / unsigned mode
//   l0, l1, l2    : A > B, A == B, A < B (valid only while valid=1)
//   busy          : compare in progress
//   valid         : l0..l2 hold a current result
//   signed_mode   : current compare mode
module nbit_serial_comp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CHUNK-1:0] y,
  input  logic             pb1,
  input  logic             pb2,
  input  logic             pb3,
  input  logic             pb4,
  output logic             l0,
  output logic             l1,
  output logic             l2,
  output logic             busy,
  output logic             valid,
  output logic             signed_mode
);

  localparam int             IDXW    = $clog2(WIDTH);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(WIDTH - 1);

  logic loadA, loadB, startCmp, toggleMode;

  cmpState_t        state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             signedMode_q, signedMode_d;
  logic [RES_W-1:0] result_q, result_d;

  logic             bitA, bitB, invertSense;

  pb_edge uPbLoadA (.clk(clk), .rst(rst), .pb_i(pb1), .press_o(loadA));
  pb_edge uPbLoadB (.clk(clk), .rst(rst), .pb_i(pb2), .press_o(loadB));
  pb_edge uPbStart (.clk(clk), .rst(rst), .pb_i(pb3), .press_o(startCmp));
  pb_edge uPbMode  (.clk(clk), .rst(rst), .pb_i(pb4), .press_o(toggleMode));

  assign bitA        = opA_q[idx_q];
  assign bitB        = opB_q[idx_q];
  assign invertSense = signedMode_q && (idx_q == IDX_TOP);

  // Next-state logic. Outside CMP, loads and the mode toggle land first so a
  // compare started in the same cycle already sees the new operands; any of
  // them drops a finished result. Inside CMP only the bit walk advances.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    opA_d        = opA_q;
    opB_d        = opB_q;
    signedMode_d = signedMode_q;
    result_d     = result_q;

    case (state_q)
      IDLE, DONE: begin
        if (loadA) opA_d = (opA_q << CHUNK) | WIDTH'(y);
        if (loadB) opB_d = (opB_q << CHUNK) | WIDTH'(y);
        if (toggleMode) signedMode_d = ~signedMode_q;
        if (loadA || loadB || toggleMode) begin
          state_d  = IDLE;
          result_d = '0;
        end
        if (startCmp) begin
          state_d  = CMP;
          idx_d    = IDX_TOP;
          result_d = '0;
        end
      end

      CMP: begin
        if (bitA != bitB) begin
          state_d  = DONE;
          result_d = mismatchResult(bitA, bitB, invertSense);
        end else if (idx_q == '0) begin
          state_d          = DONE;
          result_d         = '0;
          result_d[RES_EQ] = 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        result_d = '0;
      end
    endcase
  end

  // State register; reset drops any compare in flight with no result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= IDX_TOP;
      opA_q        <= '0;
      opB_q        <= '0;
      signedMode_q <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      opA_q        <= opA_d;
      opB_q        <= opB_d;
      signedMode_q <= signedMode_d;
      result_q     <= result_d;
    end
  end

  assign l0          = result_q[RES_GT];
  assign l1          = result_q[RES_EQ];
  assign l2          = result_q[RES_LT];
  assign busy        = (state_q == CMP);
  assign valid       = (state_q == DONE);
  assign signed_mode = signedMode_q;

endmodule

// File: tb/tb_nbit_serial_comp.sv
// tb_nbit_serial_comp -- scoreboard bench for nbit_serial_comp.
// Stimulus pushes the expected result/latency of every compare into a queue;
// a monitor pops an entry whenever valid rises and compares.
module tb_nbit_serial_comp;

  localparam int WIDTH = 7;
  localparam int CHUNK = 4;
  localparam int OPMASK = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CHUNK-1:0] y   = '0;
  logic             pb1 = 1'b0, pb2 = 1'b0, pb3 = 1'b0, pb4 = 1'b0;
  logic             l0, l1, l2, busy, valid, signed_mode;

  nbit_serial_comp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .y(y),
    .pb1(pb1), .pb2(pb2), .pb3(pb3), .pb4(pb4),
    .l0(l0), .l1(l1), .l2(l2),
    .busy(busy), .valid(valid), .signed_mode(signed_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] res;   // bit0 = A>B, bit1 = A==B, bit2 = A<B
    int         lat;
  } expect_t;

  expect_t sbQueue[$];
  int      vectorsApplied = 0;
  int      miscompares    = 0;

  int refA = 0, refB = 0;
  bit refSigned = 1'b0;
  bit refValid  = 1'b0;

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference compare from plain integer arithmetic; latency is set by the
  // highest differing bit position.
  function automatic expect_t refCompare(input int a, input int b, input bit sgn);
    expect_t e;
    int sa = a;
    int sb = b;
    if (sgn) begin
      if (a >= (1 << (WIDTH - 1))) sa = a - (1 << WIDTH);
      if (b >= (1 << (WIDTH - 1))) sb = b - (1 << WIDTH);
    end
    if (sa > sb)       e.res = 3'b001;
    else if (sa == sb) e.res = 3'b010;
    else               e.res = 3'b100;
    e.lat = WIDTH;
    for (int i = 0; i < WIDTH; i++)
      if (((a ^ b) >> i) & 1) e.lat = WIDTH - i;
    return e;
  endfunction

  // Press the buttons in mask {pb4,pb3,pb2,pb1} for holdCycles, release, and
  // allow one more cycle for the press to take effect. The model ignores
  // presses made while a compare is running.
  task automatic applyStimulus(input logic [3:0] mask, input logic [CHUNK-1:0] yv,
                               input int holdCycles, input bit duringCompare);
    if (!duringCompare) begin
      if (mask[0]) refA = ((refA << CHUNK) | int'(yv)) & OPMASK;
      if (mask[1]) refB = ((refB << CHUNK) | int'(yv)) & OPMASK;
      if (mask[3]) refSigned = !refSigned;
      if (mask[0] || mask[1] || mask[3]) refValid = 1'b0;
      if (mask[2]) begin
        sbQueue.push_back(refCompare(refA, refB, refSigned));
        refValid = 1'b0;
      end
    end
    @(negedge clk);
    y = yv;
    {pb4, pb3, pb2, pb1} = mask;
    repeat (holdCycles) @(negedge clk);
    {pb4, pb3, pb2, pb1} = 4'b0000;
    @(negedge clk);
  endtask

  // Wait for the running compare to finish, bounded.
  task automatic waitIdle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("compare timeout", busy, 0);
    refValid = 1'b1;
  endtask

  // Reset pulse away from the clock edge; outputs must clear at once.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset l0", l0, 0);
    checkOutput("reset l1", l1, 0);
    checkOutput("reset l2", l2, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset valid", valid, 0);
    checkOutput("reset signed_mode", signed_mode, 0);
    sbQueue.delete();
    refA = 0; refB = 0; refSigned = 1'b0; refValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: time each compare from busy rising to valid rising and check
  // the result against the oldest queued expectation.
  int      cycleCount = 0;
  int      riseCycle  = 0;
  logic    prevBusy   = 1'b0;
  logic    prevValid  = 1'b0;
  expect_t monExp;

  always @(negedge clk) begin
    cycleCount++;
    if (busy && !prevBusy) riseCycle = cycleCount;
    if (valid && !prevValid) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected valid", 1, 0);
      end else begin
        monExp = sbQueue.pop_front();
        checkOutput("result {l2,l1,l0}", {29'd0, l2, l1, l0}, {29'd0, monExp.res});
        checkOutput("latency", cycleCount - riseCycle, monExp.lat);
        checkOutput("busy with valid", busy, 0);
      end
    end
    prevBusy  = busy;
    prevValid = valid;
  end

  initial begin
    #200000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

  initial begin
    int        op;
    logic [CHUNK-1:0] rv;
    repeat (2) @(negedge clk);
    doReset();

    // Two chunks into A, one into B, compare: A > B at bit 4.
    applyStimulus(4'b0001, 4'b0001, 1, 0);
    applyStimulus(4'b0001, 4'b0101, 1, 0);
    applyStimulus(4'b0010, 4'b0011, 1, 0);
    applyStimulus(4'b0100, 4'b0000, 1, 0);
    waitIdle();
    checkOutput("A>B l0", l0, 1);

    // Equal operands loaded together, full-length compare.
    doReset();
    applyStimulus(4'b0011, 4'b0010, 1, 0);
    applyStimulus(4'b0011, 4'b1010, 1, 0);
    applyStimulus(4'b0100, 4'b0000, 1, 0);
    waitIdle();
    checkOutput("A==B l1", l1, 1);

    // -1 vs 1 in signed and then unsigned mode.
    doReset();
    applyStimulus(4'b1000, 4'b0000, 1, 0);
    checkOutput("signed_mode on", signed_mode, 1);
    applyStimulus(4'b0001, 4'b1111, 1, 0);
    applyStimulus(4'b0001, 4'b1111, 1, 0);
    applyStimulus(4'b0010, 4'b0001, 1, 0);
    applyStimulus(4'b0100, 4'b0000, 1, 0);
    waitIdle();
    checkOutput("signed -1<1 l2", l2, 1);
    applyStimulus(4'b1000, 4'b0000, 1, 0);
    checkOutput("mode toggle clears valid", valid, 0);
    checkOutput("signed_mode off", signed_mode, 0);
    applyStimulus(4'b0100, 4'b0000, 1, 0);
    waitIdle();
    checkOutput("unsigned 127>1 l0", l0, 1);

    // Held button shifts once; loads and pb3 during a compare are ignored.
    doReset();
    applyStimulus(4'b0001, 4'b0001, 10, 0);
    applyStimulus(4'b0010, 4'b0001, 1, 0);
    applyStimulus(4'b0100, 4'b0000, 1, 0);
    waitIdle();
    checkOutput("held pb1 l1", l1, 1);
    applyStimulus(4'b0100, 4'b0000, 1, 0);
    applyStimulus(4'b0001, 4'b1111, 1, 1);
    applyStimulus(4'b0100, 4'b0000, 1, 1);
    waitIdle();
    applyStimulus(4'b0100, 4'b0000, 1, 0);
    waitIdle();
    checkOutput("pb1 in CMP ignored l1", l1, 1);

    // Reset at cycle 3 of a 7-cycle compare, then a fresh compare.
    doReset();
    applyStimulus(4'b0100, 4'b0000, 1, 0);
    repeat (2) @(negedge clk);
    doReset();
    repeat (10) @(negedge clk);
    checkOutput("no valid after reset", valid, 0);
    applyStimulus(4'b0100, 4'b0000, 1, 0);
    waitIdle();
    checkOutput("fresh compare l1", l1, 1);

    // Load and start in the same press; then a load clears the result.
    doReset();
    applyStimulus(4'b0101, 4'b0110, 1, 0);
    waitIdle();
    checkOutput("load+start l0", l0, 1);
    applyStimulus(4'b0001, 4'b0000, 1, 0);
    checkOutput("load clears valid", valid, 0);
    checkOutput("load clears l0", l0, 0);

    // Randomized mix of loads, mode toggles and compares.
    doReset();
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 5);
      rv = CHUNK'($urandom_range(0, (1 << CHUNK) - 1));
      case (op)
        0: applyStimulus(4'b0001, rv, 1, 0);
        1: applyStimulus(4'b0010, rv, 1, 0);
        2: applyStimulus(4'b0011, rv, 1, 0);
        3: applyStimulus(4'b1000, rv, 1, 0);
        4: applyStimulus(4'b0100, rv, 1, 0);
        default: applyStimulus(4'b0101, rv, 1, 0);
      endcase
      if (op >= 4) begin
        waitIdle();
      end else begin
        checkOutput("rand valid", valid, {31'd0, refValid});
        checkOutput("rand signed_mode", signed_mode, {31'd0, refSigned});
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", sbQueue.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
